// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: FSM states,
// slice width and slice-count helper.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CLA_SLICE = 4;

    function automatic int unsigned nslice(input int unsigned width);
        return width / CLA_SLICE;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice built from generate/propagate terms.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p, no ripple between bits.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c;
    assign c3 = c[3];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one shared 4-bit CLA slice, one slice per clock, LSB first,
// with the inter-slice carry held in a register and a start/done handshake.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = CLA_SLICE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned NSLICE = nslice(WIDTH);
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("cla_seq_adder: WIDTH must be a multiple of SLICE");
    end
    if (SLICE != CLA_SLICE) begin : g_slice_check
        $error("cla_seq_adder: SLICE is fixed by the CLA slice");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_c3;
    logic             slice_co;
    logic             accept;

    // Slice-select mux feeding the shared CLA slice.
    assign slice_a = a_r[cnt*SLICE +: SLICE];
    assign slice_b = b_r[cnt*SLICE +: SLICE];
    assign accept  = start && (state == IDLE || state == DONE);

    cla4_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_r),
        .s  (slice_s),
        .c3 (slice_c3),
        .co (slice_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= ci;
                        cnt     <= '0;
                        s       <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    s[cnt*SLICE +: SLICE] <= slice_s;
                    carry_r               <= slice_co;
                    if (cnt == CW'(NSLICE - 1)) begin
                        co    <= slice_co;
                        ovf   <= slice_c3 ^ slice_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
